// File: rtl/sp_sram_acc_sch_pkg.sv
// ---------------------------------------------------------------------------
// sp_sram_acc_sch_pkg
// Shared definitions for the single-port SRAM access scheduler:
//   gnt_e          : per-cycle SRAM grant (idle / read / write)
//   STARVE_MAX_DEF : default read-burst limit while writes are pending
//   STAT_WD        : width of the optional statistics counters
//   sat_inc        : saturating increment used by those counters
// ---------------------------------------------------------------------------
package sp_sram_acc_sch_pkg;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    localparam int STARVE_MAX_DEF = 4;
    localparam int STAT_WD        = 16;

    function automatic logic [STAT_WD-1:0] sat_inc(input logic [STAT_WD-1:0] v);
        return (&v) ? v : v + STAT_WD'(1);
    endfunction

endpackage

// File: rtl/sp_sram_acc_sch_if.sv
// ---------------------------------------------------------------------------
// sp_sram_acc_sch_if
// Client-side bus of the SRAM scheduler. Signal suffixes are from the
// scheduler's point of view (_i = into the scheduler, _o = out of it).
//   wr_val_i/wr_adr_i/wr_dat_i, wr_rdy_o : write request channel
//   rd_val_i/rd_adr_i, rd_rdy_o          : read request channel
//   rd_val_o/rd_dat_o                    : read return (1 cycle after grant)
// Modports: master = client, slave = scheduler.
// ---------------------------------------------------------------------------
interface sp_sram_acc_sch_if #(
    parameter int ADDR_WD = 10,
    parameter int DATA_WD = 32
);
    logic               wr_val_i;
    logic [ADDR_WD-1:0] wr_adr_i;
    logic [DATA_WD-1:0] wr_dat_i;
    logic               wr_rdy_o;
    logic               rd_val_i;
    logic [ADDR_WD-1:0] rd_adr_i;
    logic               rd_rdy_o;
    logic               rd_val_o;
    logic [DATA_WD-1:0] rd_dat_o;

    modport master (
        output wr_val_i, wr_adr_i, wr_dat_i, rd_val_i, rd_adr_i,
        input  wr_rdy_o, rd_rdy_o, rd_val_o, rd_dat_o
    );

    modport slave (
        input  wr_val_i, wr_adr_i, wr_dat_i, rd_val_i, rd_adr_i,
        output wr_rdy_o, rd_rdy_o, rd_val_o, rd_dat_o
    );
endinterface

// File: rtl/sp_sram_acc_wbuf.sv
// ---------------------------------------------------------------------------
// sp_sram_acc_wbuf
// Two-entry in-order write buffer (address + data).
//   clk, rstn      : clock, asynchronous active-low reset
//   push_i         : store push_adr_i/push_dat_i (caller guarantees count < 2)
//   pop_i          : retire the head entry (caller guarantees count > 0)
//   cmp_adr_i      : address compared against every valid entry
//   count_o        : number of valid entries (0..2)
//   head_adr_o/dat : oldest entry
//   hit_o[n]       : entry n is valid and holds cmp_adr_i
// ---------------------------------------------------------------------------
module sp_sram_acc_wbuf #(
    parameter int ADDR_WD = 10,
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               push_i,
    input  logic [ADDR_WD-1:0] push_adr_i,
    input  logic [DATA_WD-1:0] push_dat_i,
    input  logic               pop_i,
    input  logic [ADDR_WD-1:0] cmp_adr_i,
    output logic [1:0]         count_o,
    output logic [ADDR_WD-1:0] head_adr_o,
    output logic [DATA_WD-1:0] head_dat_o,
    output logic [1:0]         hit_o
);

    logic [ADDR_WD-1:0] adr_q [2];
    logic [DATA_WD-1:0] dat_q [2];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [1:0]         count_q, count_d;
    logic [1:0]         vld;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ~wr_ptr_q;
        if (pop_i)  rd_ptr_d = ~rd_ptr_q;
        // push and pop together leave the count unchanged
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                adr_q[i] <= '0;
                dat_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                adr_q[wr_ptr_q] <= push_adr_i;
                dat_q[wr_ptr_q] <= push_dat_i;
            end
        end
    end

    // An entry is live when the buffer is full, or when it is the head of a
    // single-entry buffer.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ent
            assign vld[gi]   = (count_q == 2'd2) ||
                               ((count_q == 2'd1) && (rd_ptr_q == 1'(gi)));
            assign hit_o[gi] = vld[gi] && (adr_q[gi] == cmp_adr_i);
        end
    endgenerate

    assign count_o    = count_q;
    assign head_adr_o = adr_q[rd_ptr_q];
    assign head_dat_o = dat_q[rd_ptr_q];

endmodule

// File: rtl/sp_sram_acc_sch.sv
// ---------------------------------------------------------------------------
// sp_sram_acc_sch
// Single-port SRAM access scheduler. Reads are issued in the cycle they are
// accepted; writes are parked in a 2-entry in-order buffer and drained when
// no read is granted, when a read hits a buffered address, or when reads
// have held the port for STARVE_MAX cycles while writes wait.
//   clk, rstn          : clock, asynchronous active-low reset
//   bus (slave)        : client write/read request and read return channels
//   sram_ena_o/wen_o   : SRAM access enable / write enable
//   sram_adr_o/dat_o   : SRAM address / write data
//   sram_dat_i         : SRAM read data, one cycle after a read access
// Optional (macro SP_SRAM_ACC_SCH_STAT_EN):
//   stat_rd_o/wr_o/hzd_o : 16-bit saturating counts of read grants, write
//                          grants and hazard-forced cycles
// ---------------------------------------------------------------------------
module sp_sram_acc_sch
    import sp_sram_acc_sch_pkg::*;
#(
    parameter int ADDR_WD    = 10,
    parameter int DATA_WD    = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    sp_sram_acc_sch_if.slave   bus,
    output logic               sram_ena_o,
    output logic               sram_wen_o,
    output logic [ADDR_WD-1:0] sram_adr_o,
    output logic [DATA_WD-1:0] sram_dat_o,
    input  logic [DATA_WD-1:0] sram_dat_i
`ifdef SP_SRAM_ACC_SCH_STAT_EN
    ,
    output logic [STAT_WD-1:0] stat_rd_o,
    output logic [STAT_WD-1:0] stat_wr_o,
    output logic [STAT_WD-1:0] stat_hzd_o
`endif
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [1:0]         wb_count;
    logic [ADDR_WD-1:0] head_adr;
    logic [DATA_WD-1:0] head_dat;
    logic [1:0]         wb_hit;
    logic               wb_push;
    logic               wb_nonempty;
    logic               hazard;
    logic               starved;
    gnt_e               gnt;
    logic [SW-1:0]      starve_q, starve_d;
    logic               rd_val_q;

    assign bus.wr_rdy_o = (wb_count < 2'd2);
    assign wb_push      = bus.wr_val_i && bus.wr_rdy_o;
    assign wb_nonempty  = (wb_count != 2'd0);
    assign hazard       = bus.rd_val_i && (|wb_hit);
    assign starved      = (32'(starve_q) >= STARVE_MAX);

    sp_sram_acc_wbuf #(
        .ADDR_WD (ADDR_WD),
        .DATA_WD (DATA_WD)
    ) u_wbuf (
        .clk        (clk),
        .rstn       (rstn),
        .push_i     (wb_push),
        .push_adr_i (bus.wr_adr_i),
        .push_dat_i (bus.wr_dat_i),
        .pop_i      (gnt == GNT_WR),
        .cmp_adr_i  (bus.rd_adr_i),
        .count_o    (wb_count),
        .head_adr_o (head_adr),
        .head_dat_o (head_dat),
        .hit_o      (wb_hit)
    );

    // Grant: read unless pending writes must go first (starvation or a
    // read-after-write hazard); otherwise drain a write if one is waiting.
    always_comb begin
        gnt      = GNT_IDLE;
        starve_d = starve_q;
        if (bus.rd_val_i && !(wb_nonempty && (starved || hazard))) begin
            gnt = GNT_RD;
        end else if (wb_nonempty) begin
            gnt = GNT_WR;
        end
        if ((gnt == GNT_WR) || !wb_nonempty) begin
            starve_d = '0;
        end else if (gnt == GNT_RD) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_q <= '0;
            rd_val_q <= 1'b0;
        end else begin
            starve_q <= starve_d;
            rd_val_q <= (gnt == GNT_RD);
        end
    end

    assign bus.rd_rdy_o = (gnt == GNT_RD);
    assign bus.rd_val_o = rd_val_q;
    assign bus.rd_dat_o = rd_val_q ? sram_dat_i : '0;

    assign sram_ena_o = (gnt != GNT_IDLE);
    assign sram_wen_o = (gnt == GNT_WR);
    assign sram_adr_o = (gnt == GNT_WR) ? head_adr : bus.rd_adr_i;
    assign sram_dat_o = (gnt == GNT_WR) ? head_dat : '0;

`ifdef SP_SRAM_ACC_SCH_STAT_EN
    logic [STAT_WD-1:0] stat_rd_q, stat_wr_q, stat_hzd_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_hzd_q <= '0;
        end else begin
            if (gnt == GNT_RD) stat_rd_q  <= sat_inc(stat_rd_q);
            if (gnt == GNT_WR) stat_wr_q  <= sat_inc(stat_wr_q);
            if (hazard)        stat_hzd_q <= sat_inc(stat_hzd_q);
        end
    end

    assign stat_rd_o  = stat_rd_q;
    assign stat_wr_o  = stat_wr_q;
    assign stat_hzd_o = stat_hzd_q;
`endif

endmodule

// File: tb/tb_sp_sram_acc_sch.sv
// ---------------------------------------------------------------------------
// tb_sp_sram_acc_sch
// Bench for the SRAM scheduler. A behavioural model (write queue, read-burst
// count, reference memory) predicts every cycle's handshake and SRAM
// activity; a simple SRAM model answers the DUT's reads.
// ---------------------------------------------------------------------------
module tb_sp_sram_acc_sch;

    localparam int AW         = 10;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int VW         = 4 + AW + DW + 1 + DW;

    logic          clk;
    logic          rstn;
    logic          sram_ena;
    logic          sram_wen;
    logic [AW-1:0] sram_adr;
    logic [DW-1:0] sram_wdat;
    logic [DW-1:0] sram_rdat;
`ifdef SP_SRAM_ACC_SCH_STAT_EN
    logic [15:0]   stat_rd, stat_wr, stat_hzd;
`endif

    sp_sram_acc_sch_if #(.ADDR_WD(AW), .DATA_WD(DW)) bus ();

    sp_sram_acc_sch #(
        .ADDR_WD    (AW),
        .DATA_WD    (DW),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .sram_ena_o (sram_ena),
        .sram_wen_o (sram_wen),
        .sram_adr_o (sram_adr),
        .sram_dat_o (sram_wdat),
        .sram_dat_i (sram_rdat)
`ifdef SP_SRAM_ACC_SCH_STAT_EN
        ,
        .stat_rd_o  (stat_rd),
        .stat_wr_o  (stat_wr),
        .stat_hzd_o (stat_hzd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model and log of the data actually written by the DUT
    logic [DW-1:0] sram_mem [1024];
    logic [DW-1:0] wlog [$];
    always @(posedge clk) begin
        if (sram_ena) begin
            if (sram_wen) begin
                sram_mem[sram_adr] <= sram_wdat;
                wlog.push_back(sram_wdat);
            end else begin
                sram_rdat <= sram_mem[sram_adr];
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } went_t;

    went_t         wq [$];
    int            starve;
    logic          exp_pend;
    logic [DW-1:0] exp_pend_dat;
    logic [DW-1:0] ref_mem [1024];
    int            exp_gnt;
    logic          exp_wr_rdy;
    logic [VW-1:0] exp_vec;
    logic          cur_wv, cur_rv;
    logic [AW-1:0] cur_wa, cur_ra;
    logic [DW-1:0] cur_wd;

    int errors = 0;
    int checks = 0;

    function automatic logic [VW-1:0] obs();
        return {bus.wr_rdy_o, bus.rd_rdy_o, sram_ena, sram_wen,
                sram_ena ? sram_adr : {AW{1'b0}},
                (sram_ena && sram_wen) ? sram_wdat : {DW{1'b0}},
                bus.rd_val_o, bus.rd_dat_o};
    endfunction

    task automatic model_reset();
        wq.delete();
        starve   = 0;
        exp_pend = 1'b0;
    endtask

    // Apply one cycle's inputs and predict the outputs for that cycle.
    task automatic drive(input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic rv, input logic [AW-1:0] ra);
        bit            hz;
        bit            ne;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        bus.wr_val_i = wv; bus.wr_adr_i = wa; bus.wr_dat_i = wd;
        bus.rd_val_i = rv; bus.rd_adr_i = ra;
        cur_wv = wv; cur_wa = wa; cur_wd = wd; cur_rv = rv; cur_ra = ra;
        hz = 0;
        foreach (wq[i]) if (rv && wq[i].adr == ra) hz = 1;
        ne = (wq.size() != 0);
        if (rv && !(ne && (hz || starve >= STARVE_MAX))) exp_gnt = 1;
        else if (ne)                                      exp_gnt = 2;
        else                                              exp_gnt = 0;
        exp_wr_rdy = (wq.size() < 2);
        ea = '0; ed = '0;
        if (exp_gnt == 2) begin ea = wq[0].adr; ed = wq[0].dat; end
        else if (exp_gnt == 1) ea = ra;
        exp_vec = {exp_wr_rdy, exp_gnt == 1, exp_gnt != 0, exp_gnt == 2, ea, ed,
                   exp_pend, exp_pend ? exp_pend_dat : {DW{1'b0}}};
        #1;
    endtask

    // Clock edge: advance the model with the inputs applied by drive().
    task automatic tick();
        int pre_n;
        @(posedge clk);
        pre_n = wq.size();
        if (exp_gnt == 2) begin
            ref_mem[wq[0].adr] = wq[0].dat;
            void'(wq.pop_front());
        end
        exp_pend = (exp_gnt == 1);
        if (exp_gnt == 1) exp_pend_dat = ref_mem[cur_ra];
        if (exp_gnt == 2 || pre_n == 0) starve = 0;
        else if (exp_gnt == 1)          starve++;
        if (cur_wv && pre_n < 2) wq.push_back('{adr: cur_wa, dat: cur_wd});
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        model_reset();
        drive(0, 0, 0, 0, 0);
        if (obs() !== exp_vec) begin errors++; $display("FAIL reset_hold got=%h want=%h", obs(), exp_vec); end
        checks++;
        if (bus.wr_rdy_o !== 1'b1 || sram_ena !== 1'b0) begin
            errors++; $display("FAIL reset_outs wr_rdy=%b ena=%b want 1/0", bus.wr_rdy_o, sram_ena);
        end
        checks++;
        tick(); tick();
        rstn = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(0, 0, 0, 0, 0);
            if (obs() !== exp_vec) begin errors++; $display("FAIL reset_rel c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            tick();
        end
    endtask

    task automatic test_single_write();
        for (int c = 0; c < 3; c++) begin
            drive(c == 0, 10'h010, 32'h11, 0, 0);
            if (obs() !== exp_vec) begin errors++; $display("FAIL single_write c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            if (c == 1 && (sram_ena !== 1'b1 || sram_wen !== 1'b1 || sram_adr !== 10'h010 || sram_wdat !== 32'h11)) begin
                errors++; $display("FAIL single_write_sram ena=%b wen=%b adr=%h dat=%h want 1/1/010/11",
                                   sram_ena, sram_wen, sram_adr, sram_wdat);
            end
            if (c == 1) checks++;
            tick();
        end
    endtask

    task automatic test_single_read();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 10'h020, 32'hC0FFEE, c == 2, 10'h020);
            if (obs() !== exp_vec) begin errors++; $display("FAIL single_read c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            if (c == 3 && (bus.rd_val_o !== 1'b1 || bus.rd_dat_o !== 32'hC0FFEE)) begin
                errors++; $display("FAIL single_read_ret val=%b dat=%h want 1/00c0ffee", bus.rd_val_o, bus.rd_dat_o);
            end
            if (c == 3) checks++;
            tick();
        end
    endtask

    task automatic test_starvation();
        int wr_idx [$];
        for (int c = 0; c < 16; c++) begin
            drive(c < 2, 10'h100 + 10'(c), 32'hD0 + 32'(c), 1, 10'h3FF);
            if (obs() !== exp_vec) begin errors++; $display("FAIL starve c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            if (sram_ena && sram_wen) wr_idx.push_back(c);
            tick();
        end
        if (wr_idx.size() != 2 || wr_idx[0] != 5 || wr_idx[1] != 10) begin
            errors++; $display("FAIL starve_pattern writes=%0d first=%0d want 2 writes at 5,10",
                               wr_idx.size(), wr_idx.size() > 0 ? wr_idx[0] : -1);
        end
        checks++;
        for (int c = 0; c < 2; c++) begin drive(0, 0, 0, 0, 0); tick(); end
    endtask

    task automatic test_hazard();
        for (int c = 0; c < 5; c++) begin
            drive(c == 0, 10'h005, 32'hAB, c == 1 || c == 2, 10'h005);
            if (obs() !== exp_vec) begin errors++; $display("FAIL hazard c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            if (c == 1 && (bus.rd_rdy_o !== 1'b0 || sram_wen !== 1'b1)) begin
                errors++; $display("FAIL hazard_stall rd_rdy=%b wen=%b want 0/1", bus.rd_rdy_o, sram_wen);
            end
            if (c == 3 && (bus.rd_val_o !== 1'b1 || bus.rd_dat_o !== 32'hAB)) begin
                errors++; $display("FAIL hazard_data val=%b dat=%h want 1/000000ab", bus.rd_val_o, bus.rd_dat_o);
            end
            if (c == 1 || c == 3) checks++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int widx = 0;
        wlog.delete();
        for (int c = 0; c < 24; c++) begin
            drive(widx < 3, 10'h200 + 10'(widx), 32'(widx + 1), c < 20, 10'h3FF);
            if (obs() !== exp_vec) begin errors++; $display("FAIL b2b c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            if (c == 2 && bus.wr_rdy_o !== 1'b0) begin
                errors++; $display("FAIL b2b_full wr_rdy=%b want 0", bus.wr_rdy_o);
            end
            if (c == 2) checks++;
            if (widx < 3 && exp_wr_rdy) widx++;
            tick();
        end
        if (wlog.size() != 3 || wlog[0] !== 32'd1 || wlog[1] !== 32'd2 || wlog[2] !== 32'd3) begin
            errors++; $display("FAIL b2b_order count=%0d first=%h want 3 writes 1,2,3",
                               wlog.size(), wlog.size() > 0 ? wlog[0] : 32'hx);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 2; c++) begin
            drive(1, 10'h300 + 10'(c), 32'hA1 + 32'(c), 1, 10'h3FF);
            if (obs() !== exp_vec) begin errors++; $display("FAIL rst_mid_fill c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            tick();
        end
        rstn = 1'b0;
        model_reset();
        wlog.delete();
        drive(0, 0, 0, 0, 0);
        if (obs() !== exp_vec) begin errors++; $display("FAIL rst_mid_async got=%h want=%h", obs(), exp_vec); end
        checks++;
        tick();
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            drive(0, 0, 0, 0, 0);
            if (obs() !== exp_vec) begin errors++; $display("FAIL rst_mid_after c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            tick();
        end
        if (wlog.size() != 0 || bus.wr_rdy_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid_discard writes=%0d wr_rdy=%b want 0/1", wlog.size(), bus.wr_rdy_o);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), $urandom(),
                  1'($urandom_range(0, 1)), 10'($urandom_range(0, 7)));
            if (obs() !== exp_vec) begin errors++; $display("FAIL random c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            tick();
        end
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0, 0);
            if (obs() !== exp_vec) begin errors++; $display("FAIL random_drain c%0d got=%h want=%h", c, obs(), exp_vec); end
            checks++;
            tick();
        end
    endtask

    initial begin
        rstn = 1'b0;
        bus.wr_val_i = 1'b0; bus.wr_adr_i = '0; bus.wr_dat_i = '0;
        bus.rd_val_i = 1'b0; bus.rd_adr_i = '0;
        sram_rdat = '0;
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        exp_pend_dat = '0;
        #2;
        test_reset();
        test_single_write();
        test_single_read();
        test_starvation();
        test_hazard();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
